// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared opcode type and parameter limits for adder_pipe
package adder_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_ACC = 2'd2,
        OP_CLR = 2'd3
    } op_e;

    localparam int ADDER_MAX_STAGES = 4;
    localparam int ADDER_MAX_WIDTH  = 32;

endpackage

// File: rtl/adder_pipe_stage.sv
// rtl/adder_pipe_stage.sv - one elastic register stage carrying an opaque payload
module adder_pipe_stage #(
    parameter int DW = 10
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
);

    assign in_ready = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid)
                out_data <= in_data;
        end
    end

endmodule

// File: rtl/adder_pipe.sv
// rtl/adder_pipe.sv - ADD/SUB/ACC/CLR unit with STAGES-deep elastic pipeline; ADDER_SAT_EN enables saturation
module adder_pipe
    import adder_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic             sat
);

    localparam int PW = WIDTH + 2;

    if (WIDTH < 2 || WIDTH > ADDER_MAX_WIDTH || STAGES < 1 || STAGES > ADDER_MAX_STAGES) begin : g_bad_param
        $error("adder_pipe: WIDTH or STAGES out of range");
    end

    logic          v [STAGES];
    logic [PW-1:0] d [STAGES];
    logic          r [STAGES+1];

    logic          s0_valid;
    logic [WIDTH:0] s0_out;
    logic          s0_sat;
    logic [WIDTH:0] acc;
    logic [WIDTH:0] acc_nxt;
    logic [WIDTH:0] res;
    logic          res_sat;
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic          accept;
`ifdef ADDER_SAT_EN
    logic [WIDTH+1:0] acc_wide;
`endif

    assign a_ext = {1'b0, in1};
    assign b_ext = {1'b0, in2};

    always_comb begin
        res     = '0;
        res_sat = 1'b0;
        acc_nxt = acc;
`ifdef ADDER_SAT_EN
        acc_wide = {1'b0, acc} + {2'b00, in1};
`endif
        case (op_e'(op))
            OP_ADD: res = a_ext + b_ext;
            OP_SUB: begin
`ifdef ADDER_SAT_EN
                if (in2 > in1) begin
                    res     = '0;
                    res_sat = 1'b1;
                end else begin
                    res = a_ext - b_ext;
                end
`else
                res = a_ext - b_ext;
`endif
            end
            OP_ACC: begin
`ifdef ADDER_SAT_EN
                if (acc_wide[WIDTH+1]) begin
                    acc_nxt = '1;
                    res_sat = 1'b1;
                end else begin
                    acc_nxt = acc_wide[WIDTH:0];
                end
`else
                acc_nxt = acc + a_ext;
`endif
                res = acc_nxt;
            end
            OP_CLR: begin
                acc_nxt = '0;
                res     = '0;
            end
        endcase
    end

    // Ready chain runs backwards from the consumer; r[STAGES] is the consumer itself.
    assign r[STAGES] = out_ready;
    assign r[0]      = !s0_valid || r[1];
    assign in_ready  = !reset && r[0];
    assign accept    = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            s0_valid <= 1'b0;
            s0_out   <= '0;
            s0_sat   <= 1'b0;
            acc      <= '0;
        end else if (r[0]) begin
            s0_valid <= accept;
            if (accept) begin
                s0_out <= res;
                s0_sat <= res_sat;
                acc    <= acc_nxt;
            end
        end
    end

    assign v[0] = s0_valid;
    assign d[0] = {s0_sat, s0_out};

    for (genvar i = 1; i < STAGES; i++) begin : g_stage
        adder_pipe_stage #(.DW(PW)) u_stage (
            .clk       (clk),
            .reset     (reset),
            .in_valid  (v[i-1]),
            .in_ready  (r[i]),
            .in_data   (d[i-1]),
            .out_valid (v[i]),
            .out_ready (r[i+1]),
            .out_data  (d[i])
        );
    end

    assign out_valid = v[STAGES-1];
    assign out       = d[STAGES-1][WIDTH:0];
    assign sat       = d[STAGES-1][WIDTH+1];

endmodule

// File: tb/tb_adder_pipe.sv
// tb/tb_adder_pipe.sv - scoreboard bench for adder_pipe (WIDTH=8, STAGES=2)
module tb_adder_pipe;
    import adder_pkg::*;

    localparam int W   = 8;
    localparam int S   = 2;
    localparam int MAXV = (1 << (W + 1)) - 1;

    logic         clk;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [1:0]   op;
    logic         out_valid;
    logic         out_ready;
    logic [W:0]   out;
    logic         sat;

    typedef struct {
        int val;
        int sat;
        int cyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   macc    = 0;
    bit   lat_check = 1'b1;
    bit   rnd_done  = 1'b0;

    adder_pipe #(.WIDTH(W), .STAGES(S)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .sat       (sat)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] o, input int a, input int b);
        exp_t e;
        int t;
        e.val = 0;
        e.sat = 0;
        e.cyc = 0;
        case (o)
            2'd0: e.val = a + b;
            2'd1: begin
                t = a - b;
                if (t < 0) begin
`ifdef ADDER_SAT_EN
                    e.val = 0;
                    e.sat = 1;
`else
                    e.val = t + MAXV + 1;
`endif
                end else begin
                    e.val = t;
                end
            end
            2'd2: begin
                t = macc + a;
                if (t > MAXV) begin
`ifdef ADDER_SAT_EN
                    t = MAXV;
                    e.sat = 1;
`else
                    t = t - (MAXV + 1);
`endif
                end
                macc  = t;
                e.val = t;
            end
            default: begin
                macc  = 0;
                e.val = 0;
            end
        endcase
        return e;
    endfunction

    // Inputs change only just after posedge, so negedge sees what the next edge will act on.
    always @(negedge clk) begin
        exp_t e;
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                check_eq("unexpected_beat", 1, 0);
            end else begin
                e = q.pop_front();
                check_eq("out", 32'(out), e.val);
                check_eq("sat", 32'(sat), e.sat);
                if (lat_check)
                    check_eq("latency", cyc - e.cyc, S);
            end
        end
        if (reset) begin
            q.delete();
            macc = 0;
        end else if (in_valid && in_ready) begin
            e = model(op, int'(in1), int'(in2));
            e.cyc = cyc;
            q.push_back(e);
        end
    end

    task automatic send(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        op  = o;
        in1 = a;
        in2 = b;
        @(negedge clk);
        while (!in_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready)
            check_eq("send_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        logic [W:0] held;
        int t;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        op        = 2'd0;
        out_ready = 1'b1;

        @(negedge clk);
        check_eq("rst_in_ready_low", 32'(in_ready), 0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_eq("rst_out", 32'(out), 0);
        check_eq("rst_out_valid", 32'(out_valid), 0);
        check_eq("rst_sat", 32'(sat), 0);
        check_eq("rst_in_ready_high", 32'(in_ready), 1);
        @(posedge clk);
        #1;

        send(OP_ADD, 8'd255, 8'd255);
        send(OP_SUB, 8'd3, 8'd5);
        send(OP_ADD, 8'd0, 8'd0);
        send(OP_SUB, 8'd200, 8'd45);

        send(OP_CLR, 8'd9, 8'd9);
        send(OP_ACC, 8'd100, 8'd0);
        send(OP_ACC, 8'd200, 8'd77);
        send(OP_ACC, 8'd44, 8'd0);
        send(OP_ACC, 8'd200, 8'd0);
        send(OP_SUB, 8'd10, 8'd10);
        repeat (S + 2) @(posedge clk);
        #1;

        lat_check = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    send(OP_ADD, 8'(i * 40 + 1), 8'(250 - i));
            end
            begin
                t = 0;
                while (!out_valid && t < 50) begin
                    @(negedge clk);
                    t++;
                end
                check_eq("bp_valid_seen", 32'(out_valid), 1);
                held = out;
                repeat (5) begin
                    @(negedge clk);
                    check_eq("bp_hold_out", 32'(out), 32'(held));
                    check_eq("bp_hold_valid", 32'(out_valid), 1);
                end
                check_eq("bp_in_ready_low", 32'(in_ready), 0);
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        repeat (S + 3) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("bp_drained", q.size(), 0);
        @(posedge clk);
        #1;

        lat_check = 1'b1;
        send(OP_ACC, 8'd5, 8'd0);
        send(OP_ACC, 8'd6, 8'd0);
        send(OP_ACC, 8'd7, 8'd0);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_no_valid", 32'(out_valid), 0);
        end
        @(posedge clk);
        #1;
        send(OP_ACC, 8'd7, 8'd0);
        repeat (S + 2) @(posedge clk);
        #1;

        lat_check = 1'b0;
        rnd_done  = 1'b0;
        fork
            begin
                for (int i = 0; i < 24; i++) begin
                    send(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
                    repeat ($urandom_range(0, 2)) @(posedge clk);
                    #1;
                end
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk);
                    #1 out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        repeat (S + 4) @(posedge clk);
        @(negedge clk);
        check_eq("final_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
